// File: rtl/usb_ls_tx.sv
// Low-speed USB packet transmitter.
// Sends SYNC, then NRZI-encoded, bit-stuffed data bytes (LSB first), then EOP,
// and drives D+/D- with an output enable.
module usb_ls_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       usbclk,
  input  logic       usbrst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       usb_dp_o,
  output logic       usb_dm_o,
  output logic       usb_oe,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  // SYNC pattern 0000_0001 sent LSB first is simply the byte 0x80.
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
  // Next bit index to send within the current byte (8 = byte exhausted);
  // reused as the period count within EOP.
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [2:0]    ones_reg, ones_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    hold_reg, hold_next;
  logic          nrzi_k_reg, nrzi_k_next;   // 1 = current NRZI level is K
  logic          dp_reg, dp_next;
  logic          dm_reg, dm_next;
  logic          oe_reg, oe_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic          wrap;
  logic          send_en;
  logic          send_val;
  logic          send_lvl;

  assign wrap = (clk_cnt_reg == LAST_CLK);

  // Register all state; reset puts the line at idle J with the pads released.
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      ones_reg    <= '0;
      shift_reg   <= '0;
      hold_reg    <= '0;
      nrzi_k_reg  <= 1'b0;
      dp_reg      <= 1'b0;
      dm_reg      <= 1'b1;
      oe_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      ones_reg    <= ones_next;
      shift_reg   <= shift_next;
      hold_reg    <= hold_next;
      nrzi_k_reg  <= nrzi_k_next;
      dp_reg      <= dp_next;
      dm_reg      <= dm_next;
      oe_reg      <= oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic: decide the content of the next bit period at each wrap.
  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = wrap ? '0 : clk_cnt_reg + 1'b1;
    bit_cnt_next = bit_cnt_reg;
    ones_next    = ones_reg;
    shift_next   = shift_reg;
    hold_next    = hold_reg;
    nrzi_k_next  = nrzi_k_reg;
    dp_next      = dp_reg;
    dm_next      = dm_reg;
    oe_next      = oe_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    tx_ready     = 1'b0;
    send_en      = 1'b0;
    send_val     = 1'b0;
    send_lvl     = nrzi_k_reg;

    case (state_reg)
      IDLE: begin
        tx_ready     = 1'b1;
        clk_cnt_next = '0;
        if (tx_valid) begin
          // First SYNC bit (a 0) goes out on the accepting edge.
          hold_next    = tx_data;
          shift_next   = SYNC_BYTE;
          bit_cnt_next = 4'd1;
          oe_next      = 1'b1;
          busy_next    = 1'b1;
          send_en      = 1'b1;
          send_val     = 1'b0;
          state_next   = SYNC;
        end
      end

      SYNC, DATA: begin
        if (wrap) begin
          if (ones_reg == 3'd6) begin
            // Stuff bit: a forced 0, data bit held back.
            send_en  = 1'b1;
            send_val = 1'b0;
          end else if (bit_cnt_reg == 4'd8) begin
            if (state_reg == SYNC) begin
              shift_next   = hold_reg;
              bit_cnt_next = 4'd1;
              send_en      = 1'b1;
              send_val     = hold_reg[0];
              state_next   = DATA;
            end else begin
              tx_ready = 1'b1;
              if (tx_valid) begin
                shift_next   = tx_data;
                bit_cnt_next = 4'd1;
                send_en      = 1'b1;
                send_val     = tx_data[0];
              end else begin
                dp_next      = 1'b0;
                dm_next      = 1'b0;
                bit_cnt_next = 4'd0;
                state_next   = EOP;
              end
            end
          end else begin
            send_en      = 1'b1;
            send_val     = shift_reg[bit_cnt_reg[2:0]];
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end

      EOP: begin
        if (wrap) begin
          if (bit_cnt_reg == 4'd0) begin
            bit_cnt_next = 4'd1;
          end else if (bit_cnt_reg == 4'd1) begin
            bit_cnt_next = 4'd2;
            dp_next      = 1'b0;
            dm_next      = 1'b1;
          end else begin
            bit_cnt_next = 4'd0;
            ones_next    = '0;
            nrzi_k_next  = 1'b0;
            oe_next      = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b1;
            state_next   = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // NRZI: a 0 toggles the level, a 1 holds it and extends the run of ones.
    if (send_en) begin
      send_lvl    = send_val ? nrzi_k_reg : ~nrzi_k_reg;
      nrzi_k_next = send_lvl;
      dp_next     = send_lvl;
      dm_next     = ~send_lvl;
      ones_next   = send_val ? ones_reg + 3'd1 : 3'd0;
    end
  end

  assign usb_dp_o = dp_reg;
  assign usb_dm_o = dm_reg;
  assign usb_oe   = oe_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_usb_ls_tx.sv
// Testbench for usb_ls_tx: packet-level line model, per-cycle compare,
// and an NRZI/destuff receiver that decodes the bytes back off the line.
module tb_usb_ls_tx;

  localparam int CPB = 8;

  logic       usbclk = 1'b0;
  logic       usbrst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       usb_dp_o;
  logic       usb_dm_o;
  logic       usb_oe;
  logic       busy;
  logic       done;

  usb_ls_tx #(.CLKS_PER_BIT(CPB)) dut (
    .usbclk   (usbclk),
    .usbrst_n (usbrst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .usb_dp_o (usb_dp_o),
    .usb_dm_o (usb_dm_o),
    .usb_oe   (usb_oe),
    .busy     (busy),
    .done     (done)
  );

  always #5 usbclk = ~usbclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  bit active = 1'b0;
  int oe_cnt = 0;
  int done_cnt = 0;

  logic [7:0] byte_q[$];
  logic [1:0] exp_sym[$];   // {dp,dm} per bit period of the expected packet
  int         rdy_q[$];     // period index at which each byte boundary falls
  logic [1:0] rx_q[$];      // mid-period line samples taken from the DUT
  bit         m_lk;
  int         m_ones;

  always @(posedge usbclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Model: one line symbol per transmitted bit, NRZI from J, stuffing after six 1s.
  function automatic void emit(input bit b);
    if (!b) m_lk = ~m_lk;
    m_ones = b ? m_ones + 1 : 0;
    exp_sym.push_back(m_lk ? 2'b10 : 2'b01);
  endfunction

  function automatic void emit_bit(input bit b);
    emit(b);
    if (m_ones == 6) emit(1'b0);
  endfunction

  function automatic void build_model();
    logic [7:0] v;
    exp_sym.delete();
    rdy_q.delete();
    m_lk = 1'b0;
    m_ones = 0;
    for (int i = 0; i < 8; i++) emit_bit(i == 7);
    foreach (byte_q[m]) begin
      v = byte_q[m];
      for (int i = 0; i < 8; i++) emit_bit(v[i]);
      rdy_q.push_back(exp_sym.size());
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b01);
  endfunction

  function automatic string model_str();
    string s = "";
    foreach (exp_sym[i])
      s = {s, (exp_sym[i] == 2'b10) ? "K" : (exp_sym[i] == 2'b01) ? "J" : "0"};
    return s;
  endfunction

  // Per-cycle compare of every output against the model (or idle values).
  always @(negedge usbclk) begin
    int c, tot;
    logic [1:0] es;
    logic eoe, ebusy, edone, erdy;
    es = 2'b01; eoe = 1'b0; ebusy = 1'b0; edone = 1'b0; erdy = 1'b1;
    c = 0;
    if (active) begin
      c = cyc - e0;
      tot = exp_sym.size() * CPB;
      if (c < tot) begin
        es = exp_sym[c / CPB]; eoe = 1'b1; ebusy = 1'b1; erdy = 1'b0;
      end else begin
        edone = 1'b1;
      end
      foreach (rdy_q[m]) if (c + 1 == rdy_q[m] * CPB) erdy = 1'b1;
      if (usb_oe) oe_cnt++;
      if (c < tot && (c % CPB) == CPB / 2) rx_q.push_back({usb_dp_o, usb_dm_o});
      if (c >= tot) active = 1'b0;
    end
    if (done) done_cnt++;
    chk($sformatf("line c=%0d", c), {30'd0, usb_dp_o, usb_dm_o}, {30'd0, es});
    chk($sformatf("oe c=%0d", c), {31'd0, usb_oe}, {31'd0, eoe});
    chk($sformatf("busy c=%0d", c), {31'd0, busy}, {31'd0, ebusy});
    chk($sformatf("done c=%0d", c), {31'd0, done}, {31'd0, edone});
    chk($sformatf("tx_ready c=%0d", c), {31'd0, tx_ready}, {31'd0, erdy});
  end

  // Present byte_q with a valid/ready handshake; returns once all bytes accepted.
  task automatic run_pkt();
    int idx = 0;
    bit acc;
    build_model();
    rx_q.delete();
    oe_cnt = 0;
    @(posedge usbclk); #1;
    tx_valid = 1'b1;
    tx_data  = byte_q[0];
    for (int g = 0; g < 5000 && idx < byte_q.size(); g++) begin
      @(negedge usbclk);
      acc = tx_ready && tx_valid;
      @(posedge usbclk); #1;
      if (acc) begin
        if (idx == 0) begin e0 = cyc; active = 1'b1; end
        idx++;
      end
      tx_valid = (idx < byte_q.size());
      tx_data  = (idx < byte_q.size()) ? byte_q[idx] : 8'($urandom);
    end
    if (idx < byte_q.size()) chk("accept_timeout", idx, byte_q.size());
  endtask

  // Wait for the packet to end, then check length, done count and decoded bytes.
  task automatic wait_end(input int exp_oe, input int exp_done);
    logic [1:0] prev;
    bit b;
    int ones;
    bit bits[$];
    logic [7:0] v;
    for (int g = 0; g < 5000 && active; g++) @(posedge usbclk);
    chk("end_timeout", {31'd0, active}, 32'd0);
    chk("oe_clocks", oe_cnt, exp_oe);
    chk("model_oe_clocks", exp_sym.size() * CPB, exp_oe);
    chk("done_pulses", done_cnt, exp_done);
    prev = 2'b01; ones = 0;
    foreach (rx_q[i]) begin
      if (rx_q[i] == 2'b00) break;
      b = (rx_q[i] == prev);
      prev = rx_q[i];
      if (ones == 6) begin ones = 0; continue; end
      ones = b ? ones + 1 : 0;
      bits.push_back(b);
    end
    chk("rx_bits", bits.size(), 8 * (byte_q.size() + 1));
    for (int m = 0; m <= byte_q.size() && 8 * m + 7 < bits.size(); m++) begin
      for (int i = 0; i < 8; i++) v[i] = bits[8 * m + i];
      if (m == 0) chk("rx_sync", v, 8'h80);
      else chk($sformatf("rx_byte%0d", m - 1), v, byte_q[m - 1]);
    end
  endtask

  initial begin
    int dref;
    usbrst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(negedge usbclk);
    chk("rst_oe", usb_oe, 0);
    chk("rst_line", {usb_dp_o, usb_dm_o}, 2'b01);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge usbclk); #1;
    usbrst_n = 1'b1;
    repeat (3) @(posedge usbclk);

    // Single 0x00 byte: all transitions.
    byte_q = '{8'h00};
    build_model();
    chk_str("model_00", model_str(), "KJKJKJKKJKJKJKJK00J");
    run_pkt();
    wait_end(152, 1);

    // 0xFF: sync's final 1 plus five data 1s forces a mid-byte stuff bit.
    byte_q = '{8'hFF};
    build_model();
    chk_str("model_FF", model_str(), "KJKJKJKKKKKKKJJJJ00J");
    run_pkt();
    wait_end(160, 2);

    // 0xFC: trailing stuff bit after the 8th bit, before EOP.
    byte_q = '{8'hFC};
    build_model();
    chk_str("model_FC", model_str(), "KJKJKJKKJKKKKKKKJ00J");
    chk("model_FC_ready_period", rdy_q[0], 17);
    run_pkt();
    wait_end(160, 3);

    // Two bytes back to back.
    byte_q = '{8'hA5, 8'h5A};
    build_model();
    chk("model_A5_ready_edge", rdy_q[0] * CPB, 128);
    run_pkt();
    wait_end(216, 4);

    // Reset 40 clocks into a packet.
    byte_q = '{8'h3C};
    run_pkt();
    repeat (40) @(posedge usbclk);
    #1;
    usbrst_n = 1'b0;
    active = 1'b0;
    dref = done_cnt;
    #1;
    chk("midrst_oe", usb_oe, 0);
    chk("midrst_line", {usb_dp_o, usb_dm_o}, 2'b01);
    chk("midrst_busy", busy, 0);
    repeat (3) @(posedge usbclk);
    #1;
    usbrst_n = 1'b1;
    repeat (30) @(posedge usbclk);
    chk("midrst_no_done", done_cnt, dref);

    // Fresh packet after reset must start its SYNC from J.
    byte_q = '{8'h00};
    run_pkt();
    wait_end(152, dref + 1);

    repeat (4) @(posedge usbclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
